// File: rtl/frame_sched_pkg.sv
// Shared definitions for the frame copy scheduler, the rectangle DMA and the GPU.
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 16
`endif

package frame_sched_pkg;

    typedef enum logic [1:0] {
        RUN,
        ARMED,
        COPY,
        RELEASE
    } frame_sched_state_t;

    localparam int DEF_RECT_COUNT     = 64;
    localparam int DEF_WORDS_PER_RECT = 6;

endpackage

// File: rtl/sat_counter.sv
// Incrementer that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/frame_copy_scheduler.sv
// Once-per-frame copy sequencer: stall CPU, wait for vblank, hand the read port to the DMA.
// Define FRAME_SCHED_STATS_EN to get live frames_dropped / frames_copied counters.
module frame_copy_scheduler
    import frame_sched_pkg::*;
#(
    parameter int ADDR_WIDTH     = `DATA_ADDR_WIDTH,
    parameter int RECT_COUNT     = DEF_RECT_COUNT,
    parameter int WORDS_PER_RECT = DEF_WORDS_PER_RECT,
    parameter int STAT_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vblank_start,
    input  logic                  cpu_frame_done,
    input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
    input  logic [ADDR_WIDTH-1:0] dma_rd_addr,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  copy_start,
    output logic                  copy_active,
    output logic                  cpu_stall,
    output logic                  cpu_resume,
    output logic [STAT_WIDTH-1:0] frames_dropped,
    output logic [STAT_WIDTH-1:0] frames_copied
);

    localparam int COPY_CYCLES = RECT_COUNT * WORDS_PER_RECT;
    localparam int CNT_W       = $clog2(COPY_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COPY_CYCLES);

    frame_sched_state_t state, next_state;
    logic [CNT_W-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= next_state;
    end

    // Counter is preloaded with 1 on the start cycle, so the start cycle
    // itself is the first of the COPY_CYCLES+1 active cycles.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (copy_start)
            cnt <= CNT_W'(1);
        else if (state == COPY && cnt != CNT_LAST)
            cnt <= cnt + CNT_W'(1);
        else if (state != COPY)
            cnt <= '0;
    end

    always_comb begin
        next_state = state;
        copy_start = 1'b0;
        cpu_stall  = 1'b0;
        cpu_resume = 1'b0;
        case (state)
            RUN: begin
                if (cpu_frame_done) begin
                    cpu_stall = 1'b1;
                    if (vblank_start) begin
                        copy_start = 1'b1;
                        next_state = COPY;
                    end else begin
                        next_state = ARMED;
                    end
                end
            end
            ARMED: begin
                cpu_stall = 1'b1;
                if (vblank_start) begin
                    copy_start = 1'b1;
                    next_state = COPY;
                end
            end
            COPY: begin
                cpu_stall = 1'b1;
                if (cnt == CNT_LAST)
                    next_state = RELEASE;
            end
            RELEASE: begin
                cpu_resume = 1'b1;
                next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    assign copy_active = copy_start | (state == COPY);
    assign mem_rd_addr = copy_active ? dma_rd_addr : cpu_rd_addr;

`ifdef FRAME_SCHED_STATS_EN
    // A vblank is lost unless it launches a copy or is the one ARMED waits for.
    logic vblank_dropped;
    assign vblank_dropped = vblank_start & ~copy_start & (state != ARMED);

    sat_counter #(.WIDTH(STAT_WIDTH)) u_dropped (
        .clk   (clk),
        .reset (reset),
        .inc   (vblank_dropped),
        .count (frames_dropped)
    );

    sat_counter #(.WIDTH(STAT_WIDTH)) u_copied (
        .clk   (clk),
        .reset (reset),
        .inc   (cpu_resume),
        .count (frames_copied)
    );
`else
    assign frames_dropped = '0;
    assign frames_copied  = '0;
`endif

endmodule

// File: tb/tb_frame_copy_scheduler.sv
// Self-checking bench for frame_copy_scheduler: timeline model plus directed literal checks.
module tb_frame_copy_scheduler;

    localparam int AW          = 16;
    localparam int COPY_CYCLES = 384;

`ifdef FRAME_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, vblank_start, cpu_frame_done;
    logic [AW-1:0] cpu_rd_addr, dma_rd_addr, mem_rd_addr;
    logic          copy_start, copy_active, cpu_stall, cpu_resume;
    logic [7:0]    frames_dropped, frames_copied;

    logic          vblank2, fd2;
    logic [AW-1:0] mem_rd_addr2;
    logic          copy_start2, copy_active2, cpu_stall2, cpu_resume2;
    logic [7:0]    frames_dropped2, frames_copied2;

    always #5 clk = ~clk;

    frame_copy_scheduler #(.ADDR_WIDTH(AW), .STAT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .vblank_start(vblank_start), .cpu_frame_done(cpu_frame_done),
        .cpu_rd_addr(cpu_rd_addr), .dma_rd_addr(dma_rd_addr), .mem_rd_addr(mem_rd_addr),
        .copy_start(copy_start), .copy_active(copy_active), .cpu_stall(cpu_stall),
        .cpu_resume(cpu_resume), .frames_dropped(frames_dropped), .frames_copied(frames_copied)
    );

    // Short-copy instance used only to reach counter saturation quickly.
    frame_copy_scheduler #(.ADDR_WIDTH(AW), .RECT_COUNT(2), .WORDS_PER_RECT(1), .STAT_WIDTH(8)) dut2 (
        .clk(clk), .reset(reset), .vblank_start(vblank2), .cpu_frame_done(fd2),
        .cpu_rd_addr(cpu_rd_addr), .dma_rd_addr(dma_rd_addr), .mem_rd_addr(mem_rd_addr2),
        .copy_start(copy_start2), .copy_active(copy_active2), .cpu_stall(cpu_stall2),
        .cpu_resume(cpu_resume2), .frames_dropped(frames_dropped2), .frames_copied(frames_copied2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: a copy launched at cycle T owns the port through T+COPY_CYCLES,
    // the following cycle is the release, and the CPU may be waiting (armed) beforehand.
    int cyc    = 0;
    int copy_t = -1;
    bit armed  = 1'b0;
    int m_drop = 0;
    int m_copy = 0;
    bit chk_en = 1'b0;

    int act_cnt = 0, last_start = -1, last_resume = -1;

    function automatic void exp_now(output bit e_start, output bit e_active, output bit e_stall,
                                    output bit e_resume, output bit e_drop);
        bit win, rel;
        win      = (copy_t >= 0) && (cyc <= copy_t + COPY_CYCLES);
        rel      = (copy_t >= 0) && (cyc == copy_t + COPY_CYCLES + 1);
        e_start  = !win && !rel && vblank_start && (armed || cpu_frame_done);
        e_active = e_start || win;
        e_stall  = e_start || win || armed || (!rel && cpu_frame_done);
        e_resume = rel;
        e_drop   = vblank_start && !e_start && !armed;
    endfunction

    function automatic int sat8(input int v);
        if (!STATS) return 0;
        return (v > 255) ? 255 : v;
    endfunction

    always @(posedge clk) begin
        bit s, a, st, r, d;
        if (reset) begin
            copy_t = -1; armed = 1'b0; m_drop = 0; m_copy = 0; chk_en = 1'b1;
        end else if (chk_en) begin
            exp_now(s, a, st, r, d);
            if (d) m_drop++;
            if (r) begin m_copy++; copy_t = -1; end
            if (s) begin copy_t = cyc; armed = 1'b0; end
            else if (!a && !r && cpu_frame_done) armed = 1'b1;
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit s, a, st, r, d;
        if (chk_en && !reset) begin
            exp_now(s, a, st, r, d);
            check("copy_start", copy_start, s);
            check("copy_active", copy_active, a);
            check("cpu_stall", cpu_stall, st);
            check("cpu_resume", cpu_resume, r);
            check("mem_rd_addr", mem_rd_addr, a ? dma_rd_addr : cpu_rd_addr);
            check("frames_dropped", frames_dropped, sat8(m_drop));
            check("frames_copied", frames_copied, sat8(m_copy));
            if (copy_start)  last_start  = cyc;
            if (copy_active) act_cnt++;
            if (cpu_resume)  last_resume = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_resume(input bit second, input int limit);
        bit got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (second ? cpu_resume2 : cpu_resume) begin
                got = 1'b1;
                break;
            end
        end
        check(second ? "resume2_seen" : "resume_seen", got, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_cyc;
        reset = 1'b1; vblank_start = 1'b0; cpu_frame_done = 1'b0;
        vblank2 = 1'b0; fd2 = 1'b0;
        cpu_rd_addr = 16'h0123; dma_rd_addr = 16'h1F00;
        tick(3);
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_copy_start", copy_start, 0);
        check("rst_copy_active", copy_active, 0);
        check("rst_cpu_stall", cpu_stall, 0);
        check("rst_cpu_resume", cpu_resume, 0);
        check("rst_mem_rd_addr", mem_rd_addr, 16'h0123);
        check("rst_stats", {frames_dropped, frames_copied}, 0);

        // Frame done at 10, vblank at 50
        act_cnt = 0;
        tick(10);
        cpu_frame_done = 1'b1;
        @(negedge clk);
        check("t1_stall_rise", cpu_stall, 1);
        stall_cyc = cyc;
        tick(40);
        vblank_start = 1'b1;
        tick(1);
        vblank_start = 1'b0;
        tick(5);
        @(negedge clk);
        check("t1_mux_dma", mem_rd_addr, 16'h1F00);
        wait_resume(1'b0, 1000);
        tick(1);
        cpu_frame_done = 1'b0;
        @(negedge clk);
        check("t1_start_offset", last_start - stall_cyc, 40);
        check("t1_active_len", act_cnt, COPY_CYCLES + 1);
        check("t1_resume_offset", last_resume - last_start, COPY_CYCLES + 1);
        check("t1_mux_cpu", mem_rd_addr, 16'h0123);

        // Frame done and vblank together straight from RUN
        tick(5);
        cpu_frame_done = 1'b1; vblank_start = 1'b1;
        @(negedge clk);
        check("t2_copy_start", copy_start, 1);
        check("t2_stall", cpu_stall, 1);
        tick(1);
        vblank_start = 1'b0;
        @(negedge clk);
        check("t2_active", copy_active, 1);
        wait_resume(1'b0, 1000);
        tick(1);
        cpu_frame_done = 1'b0;

        // Two idle vblanks plus one during COPY are dropped
        tick(3); vblank_start = 1'b1; tick(1); vblank_start = 1'b0;
        tick(3); vblank_start = 1'b1; tick(1); vblank_start = 1'b0;
        tick(2);
        cpu_frame_done = 1'b1; vblank_start = 1'b1; tick(1); vblank_start = 1'b0;
        tick(20); vblank_start = 1'b1; tick(1); vblank_start = 1'b0;
        wait_resume(1'b0, 1000);
        tick(1);
        cpu_frame_done = 1'b0;
        tick(2);
        @(negedge clk);
        check("t3_dropped", frames_dropped, STATS ? 3 : 0);
        check("t3_copied", frames_copied, STATS ? 3 : 0);

        // Reset in the middle of a copy, then a clean handshake
        tick(1);
        cpu_frame_done = 1'b1; vblank_start = 1'b1; tick(1); vblank_start = 1'b0;
        tick(199);
        reset = 1'b1; cpu_frame_done = 1'b0;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("t4_active_after_rst", copy_active, 0);
        check("t4_stall_after_rst", cpu_stall, 0);
        check("t4_start_after_rst", copy_start, 0);
        tick(5);
        cpu_frame_done = 1'b1;
        tick(10);
        vblank_start = 1'b1; tick(1); vblank_start = 1'b0;
        wait_resume(1'b0, 1000);
        tick(1);
        cpu_frame_done = 1'b0;
        tick(2);
        @(negedge clk);
        check("t4_copied", frames_copied, STATS ? 1 : 0);
        check("t4_dropped", frames_dropped, 0);

        // 300 short frames saturate the copied counter
        for (int i = 1; i <= 300; i++) begin
            tick(1);
            fd2 = 1'b1; vblank2 = 1'b1;
            @(negedge clk);
            check("t5_start2", copy_start2, 1);
            tick(1);
            vblank2 = 1'b0;
            wait_resume(1'b1, 20);
            tick(1);
            fd2 = 1'b0;
            @(negedge clk);
            check("t5_copied2", frames_copied2, sat8(i));
        end
        check("t5_saturated", frames_copied2, STATS ? 255 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
